// File: rtl/iwtu_top.sv
// rtl/iwtu_top.sv - inverse lifting-Haar wavelet transform unit
//
// Reads one block of WIDTH=2^DEPTH S-transform coefficients (s_top, d_DEPTH,
// d_DEPTH-1[0..1], ..., d_1[0..WIDTH/2-1]) from a show-ahead coefficient
// source, reconstructs WIDTH samples over DEPTH levels and writes them in
// order to the output sample FIFO.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   mem_ready   coefficient word available on mem_data (show-ahead)
//   mem_data    current coefficient, signed two's complement
//   mem_rd_en   pops the current coefficient (LOAD only, only when mem_ready)
//   fifo_full   output FIFO cannot accept a write this cycle
//   fifo_wr_en  fifo_data is written this cycle
//   fifo_data   reconstructed sample
//   busy        high in RECON and DRAIN
//   block_done  pulse on the cycle the last sample of a block is written

module iwtu_top #(
  parameter int BITWIDTH = 24,
  parameter int DEPTH    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ready,
  input  logic [BITWIDTH-1:0] mem_data,
  output logic                mem_rd_en,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [BITWIDTH-1:0] fifo_data,
  output logic                busy,
  output logic                block_done
);

  localparam int WIDTH = 1 << DEPTH;
  localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(WIDTH - 1);
  localparam logic [DEPTH:0]   M_ONE    = (DEPTH+1)'(1);
  localparam logic [DEPTH:0]   M_LAST   = (DEPTH+1)'(WIDTH / 2);

  typedef enum logic [1:0] {LOAD, RECON, DRAIN} state_t;

  state_t           state;
  logic [DEPTH-1:0] k;      // load word index
  logic [DEPTH-1:0] i;      // pair index within the current level
  logic [DEPTH-1:0] j;      // drain sample index
  logic [DEPTH:0]   m;      // approximations at the start of the current level
  logic             sel;    // bank holding the current level's input

  // Ping-pong banks. LOAD writes every coefficient into both banks, so the
  // entries at index >= 2m (detail words not yet consumed) are already present
  // in whichever bank a level writes into and never need an explicit copy.
  logic [BITWIDTH-1:0] bank [2][WIDTH];

  logic [DEPTH-1:0] idx_d, idx_e, idx_o;
  logic signed [BITWIDTH-1:0] a_w, d_w, h_w, x_even, x_odd;
  logic pair_last;

  assign idx_d = DEPTH'(m + {1'b0, i});
  assign idx_e = DEPTH'({i, 1'b0});
  assign idx_o = idx_e | DEPTH'(1);

  assign a_w    = bank[sel][i];
  assign d_w    = bank[sel][idx_d];
  assign h_w    = d_w >>> 1;
  assign x_even = a_w - h_w;
  assign x_odd  = d_w + x_even;

  assign pair_last = (({1'b0, i} + M_ONE) == m);

  // Handshakes are combinational on the current inputs; rst suppresses them
  // immediately so a reset cycle can never pop or write.
  assign mem_rd_en  = !rst && (state == LOAD) && mem_ready;
  assign fifo_wr_en = !rst && (state == DRAIN) && !fifo_full;
  assign fifo_data  = (!rst && state == DRAIN) ? bank[sel][j] : '0;
  assign busy       = !rst && (state == RECON || state == DRAIN);
  assign block_done = fifo_wr_en && (j == LAST_IDX);

  always_ff @(posedge clk) begin
    if (mem_rd_en) begin
      bank[0][k] <= mem_data;
      bank[1][k] <= mem_data;
    end else if (!rst && state == RECON) begin
      bank[~sel][idx_e] <= x_even;
      bank[~sel][idx_o] <= x_odd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      k     <= '0;
      i     <= '0;
      j     <= '0;
      m     <= '0;
      sel   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (mem_rd_en) begin
            if (k == LAST_IDX) begin
              k     <= '0;
              i     <= '0;
              m     <= M_ONE;
              sel   <= 1'b0;
              state <= RECON;
            end else begin
              k <= k + DEPTH'(1);
            end
          end
        end
        RECON: begin
          if (pair_last) begin
            // Level end: swap banks in the same cycle as the last pair.
            i   <= '0;
            sel <= ~sel;
            if (m == M_LAST) begin
              j     <= '0;
              state <= DRAIN;
            end else begin
              m <= m << 1;
            end
          end else begin
            i <= i + DEPTH'(1);
          end
        end
        DRAIN: begin
          if (fifo_wr_en) begin
            if (j == LAST_IDX) begin
              j     <= '0;
              state <= LOAD;
            end else begin
              j <= j + DEPTH'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_iwtu_top.sv
// tb/tb_iwtu_top.sv - scoreboard bench for iwtu_top
module tb_iwtu_top;

  localparam int BW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic          mem_ready, mem_rd_en, fifo_full, fifo_wr_en, busy, block_done;
  logic [BW-1:0] mem_data, fifo_data;

  logic          m1_ready, m1_rd_en, m1_fifo_full, m1_wr_en, m1_busy, m1_done;
  logic [BW-1:0] m1_data, m1_fdata;

  iwtu_top #(.BITWIDTH(BW), .DEPTH(3)) u_dut (
    .clk(clk), .rst(rst),
    .mem_ready(mem_ready), .mem_data(mem_data), .mem_rd_en(mem_rd_en),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .busy(busy), .block_done(block_done)
  );

  iwtu_top #(.BITWIDTH(BW), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .mem_ready(m1_ready), .mem_data(m1_data), .mem_rd_en(m1_rd_en),
    .fifo_full(m1_fifo_full), .fifo_wr_en(m1_wr_en), .fifo_data(m1_fdata),
    .busy(m1_busy), .block_done(m1_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bd_cnt = 0;
  int bd1_cnt = 0;
  int gap_ph = 0;
  int bp_wr = 0;

  logic [BW-1:0] mem_q[$];
  logic [BW-1:0] mem1_q[$];
  logic [BW:0]   exp_q[$];
  logic [BW:0]   exp1_q[$];
  logic [BW:0]   mon_e;

  bit mem_en = 0, mem1_en = 0, gap_mode = 0, bp_armed = 0, bp_done = 0;
  bit pop0, pop1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_ramp(input bit with_exp);
    logic [BW-1:0] w [8] = '{24'h000480, 24'h000400, 24'h000200, 24'h000200,
                             24'h000100, 24'h000100, 24'h000100, 24'h000100};
    for (int n = 0; n < 8; n++) begin
      mem_q.push_back(w[n]);
      if (with_exp) exp_q.push_back({n == 7, BW'((n + 1) * 256)});
    end
  endfunction

  // Coefficient source: pops at the edge following a cycle with mem_rd_en.
  initial begin
    mem_ready = 0; mem_data = '0; m1_ready = 0; m1_data = '0;
    forever begin
      @(negedge clk);
      pop0 = mem_rd_en;
      pop1 = m1_rd_en;
      @(posedge clk);
      #1;
      if (pop0 && mem_q.size() > 0) void'(mem_q.pop_front());
      if (pop1 && mem1_q.size() > 0) void'(mem1_q.pop_front());
      gap_ph = (gap_ph + 1) % 3;
      mem_ready = mem_en && (mem_q.size() > 0) && (!gap_mode || gap_ph == 0);
      mem_data  = (mem_q.size() > 0) ? mem_q[0] : '0;
      m1_ready  = mem1_en && (mem1_q.size() > 0);
      m1_data   = (mem1_q.size() > 0) ? mem1_q[0] : '0;
    end
  end

  // Back-pressure: fifo_full for 3 cycles right after the 3rd write.
  initial begin
    fifo_full = 0; m1_fifo_full = 0;
    forever begin
      @(negedge clk);
      if (bp_armed && fifo_wr_en) begin
        bp_wr++;
        if (bp_wr == 3) begin
          @(posedge clk);
          #1 fifo_full = 1;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_no_write", fifo_wr_en, 0);
            check("stall_data_held", fifo_data, 24'h000400);
          end
          @(posedge clk);
          #1 fifo_full = 0;
          bp_armed = 0;
          bp_done = 1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a DUT writes.
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %h, required no write", fifo_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample", fifo_data, mon_e[BW-1:0]);
          check("block_done", BW'(block_done), BW'(mon_e[BW]));
        end
      end else begin
        check("done_without_write", BW'(block_done), 0);
      end
      if (block_done) bd_cnt++;
      if (!mem_ready) check("rd_without_ready", BW'(mem_rd_en), 0);
      if (busy) check("rd_while_busy", BW'(mem_rd_en), 0);
      if (m1_wr_en) begin
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write_d1: got %h, required no write", m1_fdata);
        end else begin
          mon_e = exp1_q.pop_front();
          check("sample_d1", m1_fdata, mon_e[BW-1:0]);
          check("block_done_d1", BW'(m1_done), BW'(mon_e[BW]));
        end
      end
      if (m1_done) bd1_cnt++;
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() > 0 || exp1_q.size() > 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({name, "_all_written"}, BW'(exp_q.size() + exp1_q.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int bd0, t0, t1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_rd_en", BW'(mem_rd_en), 0);
    check("rst_fifo_wr_en", BW'(fifo_wr_en), 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_busy", BW'(busy), 0);
    check("rst_block_done", BW'(block_done), 0);
    check("rst_d1_busy", BW'(m1_busy), 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("idle_busy", BW'(busy), 0);

    // Ramp with latency check
    bd0 = bd_cnt;
    push_ramp(1);
    @(posedge clk);
    #1 mem_en = 1;
    t0 = -1;
    for (int n = 0; n < 50 && t0 < 0; n++) begin
      @(negedge clk);
      if (mem_rd_en) t0 = cyc;
    end
    t1 = -1000;
    for (int n = 0; n < 100 && t1 < 0; n++) begin
      @(negedge clk);
      if (fifo_wr_en) t1 = cyc;
    end
    check("first_write_latency", BW'(t1 - t0), 15);
    wait_drain("ramp");
    check("ramp_done_count", BW'(bd_cnt - bd0), 1);

    // Constant block
    bd0 = bd_cnt;
    mem_q.push_back(24'h123400);
    for (int n = 0; n < 7; n++) mem_q.push_back(24'h000000);
    for (int n = 0; n < 8; n++) exp_q.push_back({n == 7, 24'h123400});
    wait_drain("const");
    check("const_done_count", BW'(bd_cnt - bd0), 1);

    // DEPTH=1 negative / wrap
    bd0 = bd1_cnt;
    mem1_q.push_back(24'h000000);
    mem1_q.push_back(24'hFFFFFF);
    exp1_q.push_back({1'b0, 24'h000001});
    exp1_q.push_back({1'b1, 24'h000000});
    mem1_en = 1;
    wait_drain("wrap");
    check("wrap_done_count", BW'(bd1_cnt - bd0), 1);

    // Back-pressure
    bd0 = bd_cnt;
    bp_wr = 0;
    bp_armed = 1;
    push_ramp(1);
    wait_drain("bp");
    check("bp_stall_applied", BW'(bp_done), 1);
    check("bp_done_count", BW'(bd_cnt - bd0), 1);

    // Source gaps, two back-to-back blocks
    bd0 = bd_cnt;
    gap_mode = 1;
    push_ramp(1);
    push_ramp(1);
    wait_drain("gaps");
    check("gaps_done_count", BW'(bd_cnt - bd0), 2);
    gap_mode = 0;

    // Reset mid-RECON
    push_ramp(0);
    t0 = 0;
    for (int n = 0; n < 100 && !busy; n++) @(negedge clk);
    check("recon_reached", BW'(busy), 1);
    mem_en = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("postrst_mem_rd_en", BW'(mem_rd_en), 0);
    check("postrst_fifo_wr_en", BW'(fifo_wr_en), 0);
    check("postrst_fifo_data", fifo_data, 0);
    check("postrst_busy", BW'(busy), 0);
    check("postrst_block_done", BW'(block_done), 0);
    repeat (4) @(negedge clk);
    bd0 = bd_cnt;
    mem_q.delete();
    push_ramp(1);
    mem_en = 1;
    wait_drain("after_rst");
    check("after_rst_done_count", BW'(bd_cnt - bd0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iwtu_top.md
Name: iwtu_top

Overview:
- Inverse wavelet transform unit. It reads one block of WIDTH=2^DEPTH lifting-Haar (S-transform) coefficients from coefficient memory and reconstructs the WIDTH samples over DEPTH levels.
- It pushes the samples in order into the output sample FIFO.
- It is the read-back and decode counterpart of wtu_top, and it exactly inverts the forward transform's coefficient layout and arithmetic.

Parameters:
- BITWIDTH, 24, width of every coefficient and sample word. Samples are carried as {sample[BITWIDTH-9:0], 8'h0}.
- DEPTH, 3, number of transform levels; block size WIDTH=2^DEPTH (localparam).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- mem_ready  input  1  coefficient word available on mem_data (show-ahead)
- mem_data  input  BITWIDTH  current coefficient, signed two's complement
- mem_rd_en  output  1  pops the current coefficient; only legal when mem_ready=1
- fifo_full  input  1  output FIFO cannot accept a write this cycle
- fifo_wr_en  output  1  fifo_data is written this cycle
- fifo_data  output  BITWIDTH  reconstructed sample
- busy  output  1  high in RECON and DRAIN
- block_done  output  1  one-cycle pulse on the cycle the last sample of a block is written

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named rst.
- Reset values: mem_rd_en=0, fifo_wr_en=0, fifo_data=0, busy=0, block_done=0. State=LOAD, all counters 0, buffer contents don't-care.
- Reset mid-operation: the partial block is discarded. No further mem_rd_en or fifo_wr_en is issued until LOAD restarts on the cycle after rst deasserts.
- Coefficient order in memory per block:
  - s_top (1 word), then d_DEPTH (1 word)
  - then d_DEPTH-1 (2 words), ..., then d_1 (WIDTH/2 words)
  - Example for DEPTH=3: s, d3, d2[0..1], d1[0..3].
- Arithmetic: all arithmetic is modulo 2^BITWIDTH. h = d>>>1 (arithmetic shift, i.e. floor(d/2)).
  - x_even = s - h
  - x_odd = d + x_even
- State LOAD:
  - mem_rd_en = mem_ready (combinational); one word is captured per cycle in which mem_rd_en=1.
  - Word k is stored to buf[k]. Gaps in mem_ready stall without loss.
  - After word WIDTH-1 is popped, go to RECON on the next cycle.
  - mem_rd_en is never asserted outside LOAD.
- State RECON:
  - Levels run L=DEPTH down to 1, with m=2^(DEPTH-L) approximations at the start of each level.
  - Each cycle processes exactly one pair i: a=cur[i], d=cur[m+i] -> nxt[2i]=x_even, nxt[2i+1]=x_odd.
  - Entries at index >= 2m pass through unchanged.
  - Ping-pong banks swap at level end with no extra cycle.
  - Total RECON duration is exactly WIDTH-1 cycles (7 for DEPTH=3), then go to DRAIN.
  - RECON ignores fifo_full and mem_ready.
- State DRAIN:
  - fifo_wr_en = !fifo_full (combinational), with fifo_data = sample[j], j=0..WIDTH-1 in order.
  - j advances only on a write. fifo_full stalls hold j and fifo_data.
  - On the write of j=WIDTH-1: block_done=1 for that cycle, and the state returns to LOAD on the next cycle.
- Minimum block period: WIDTH (load) + WIDTH-1 (recon) + WIDTH (drain) cycles.
- No overlap between blocks: the next block's first mem_rd_en comes no earlier than the cycle after block_done.
- Simultaneous events: fifo_full rising on the same cycle as the last sample means no write, no block_done, and the stall is held.

Test Plan:
- Ramp vector, DEPTH=3:
  - Stimulus: mem words 0x000480, 0x000400, 0x000200, 0x000200, 0x000100 x4, mem_ready=1, fifo_full=0.
  - Required response: fifo_data 0x000100, 0x000200, ..., 0x000800 on 8 consecutive fifo_wr_en cycles.
  - Timing: first write exactly 15 cycles after the first mem_rd_en; block_done coincides with 0x000800.
- Constant block:
  - Stimulus: s=0x123400, all d=0.
  - Required response: eight writes of 0x123400.
- Negative and wrap:
  - Stimulus: DEPTH=1, words 0x000000, 0xFFFFFF.
  - Required response: outputs 0x000001 then 0x000000.
- Back-pressure:
  - Stimulus: ramp vector with fifo_full=1 for 3 cycles after the 3rd write.
  - Required response: no fifo_wr_en during the stall; fifo_data held at 0x000400; sequence complete with no skipped or duplicated samples; block_done once.
- Source gaps:
  - Stimulus: mem_ready toggled 1,0,0,1,... during LOAD.
  - Required response: mem_rd_en only when mem_ready=1; identical outputs to the ramp test.
  - Follow-on: two back-to-back blocks produce 16 correct writes and 2 block_done pulses.
- Reset mid-RECON:
  - Stimulus: assert rst for 1 cycle at RECON cycle 3.
  - Required response: all outputs 0 the next cycle and busy=0; a fresh ramp block afterwards reconstructs correctly with no stale writes.
